// File: rtl/cskipa_accum_42bit.sv
// Streaming accumulator: sums a requested number of terms through a carry-skip adder
// and counts adder carry-outs (saturating), with a valid/ready result handshake.

module CSkipA_42bit #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned BLK   = 4
) (
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             carry;
    logic             blk_cin;
    logic             blk_p;

    assign p = i_add_term1 ^ i_add_term2;
    assign g = i_add_term1 & i_add_term2;

    // Ripple inside each BLK-bit group; a fully-propagating group forwards its carry-in.
    always_comb begin
        sum     = '0;
        carry   = 1'b0;
        blk_cin = 1'b0;
        blk_p   = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i % BLK == 0) begin
                blk_cin = carry;
                blk_p   = 1'b1;
            end
            sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
            blk_p  = blk_p & p[i];
            if ((i % BLK == BLK - 1) || (i == WIDTH - 1)) begin
                carry = blk_p ? blk_cin : carry;
            end
        end
        cout = carry;
    end
endmodule

module cskipa_accum_42bit #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_terms,
    input  logic [WIDTH-1:0] i_term,
    input  logic             i_term_valid,
    output logic             o_term_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [CNT_W-1:0] o_carry_cnt,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    CSkipA_42bit #(
        .WIDTH (WIDTH),
        .BLK   (4)
    ) u_adder (
        .i_add_term1 (acc_q),
        .i_add_term2 (i_term),
        .sum         (add_sum),
        .cout        (add_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d   = '0;
                    carry_d = '0;
                    rem_d   = i_num_terms;
                    state_d = (i_num_terms == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (i_term_valid) begin
                    acc_d = add_sum;
                    if (add_cout && (carry_q != {CNT_W{1'b1}})) begin
                        carry_d = carry_q + CNT_W'(1);
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

    assign o_term_ready   = (state_q == ACCUM);
    assign o_result_valid = (state_q == DONE);
    assign o_busy         = (state_q != IDLE);
    assign o_result       = acc_q;
    assign o_carry_cnt    = carry_q;
endmodule
